refresh_scoreboard_epoch: RTL and testbench

//  Parametrised GC-DRAM refresh scoreboard with a retention-epoch timer.
//  - Holds one "fresh" bit per row; user accesses (read/write restore the cell) and completed refreshes set it.
//  - Issues refresh requests only for stale rows via a req/ack handshake to the array controller.
//  - Clears the map every retention epoch; flags rows left stale at epoch end as a miss.

---
 rtl/refresh_scoreboard_epoch_if.sv | 42 ++++
 rtl/refresh_scoreboard_epoch.sv | 175 +++++++++++++++++
 tb/tb_refresh_scoreboard_epoch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/refresh_scoreboard_epoch_if.sv
// Handshake bundle between the refresh scoreboard and its array controller.
// REFRESH_STATS_EN adds the per-epoch user/refresh statistics outputs.
interface refresh_scoreboard_epoch_if #(
    parameter int ADDR_W = 7,
    parameter int MISS_W = 8
);
    logic              en;
    logic              user_vld;
    logic [ADDR_W-1:0] user_addr;
    logic              ref_ack;
    logic              ref_req;
    logic [ADDR_W-1:0] ref_addr;
    logic              done;
    logic              urgent;
    logic [ADDR_W:0]   fresh_cnt;
    logic              miss;
    logic [MISS_W-1:0] miss_cnt;
`ifdef REFRESH_STATS_EN
    logic [ADDR_W:0]   stat_user;
    logic [ADDR_W:0]   stat_ref;

    modport master (
        output en, user_vld, user_addr, ref_ack,
        input  ref_req, ref_addr, done, urgent, fresh_cnt, miss, miss_cnt,
        input  stat_user, stat_ref
    );
    modport slave (
        input  en, user_vld, user_addr, ref_ack,
        output ref_req, ref_addr, done, urgent, fresh_cnt, miss, miss_cnt,
        output stat_user, stat_ref
    );
`else
    modport master (
        output en, user_vld, user_addr, ref_ack,
        input  ref_req, ref_addr, done, urgent, fresh_cnt, miss, miss_cnt
    );
    modport slave (
        input  en, user_vld, user_addr, ref_ack,
        output ref_req, ref_addr, done, urgent, fresh_cnt, miss, miss_cnt
    );
`endif
endinterface

// File: rtl/refresh_scoreboard_epoch.sv
// Gain-cell DRAM refresh scoreboard: per-row fresh map, stale-row refresh requests, retention epoch timer.
// Optional macro REFRESH_STATS_EN adds per-epoch user/refresh first-mark statistics.
module refresh_scoreboard_epoch #(
    parameter int ROWS          = 128,
    parameter int ADDR_W        = $clog2(ROWS),
    parameter int RET_CYCLES    = 4096,
    parameter int URGENT_MARGIN = 256,
    parameter int MISS_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    refresh_scoreboard_epoch_if.slave bus
);
    localparam int                  EPOCH_W    = $clog2(RET_CYCLES);
    localparam int                  URG_TH     = RET_CYCLES - URGENT_MARGIN;
    localparam logic [EPOCH_W-1:0]  EPOCH_LAST = EPOCH_W'(RET_CYCLES - 1);
    localparam logic [ADDR_W:0]     ROWS_CNT   = (ADDR_W + 1)'(ROWS);

    typedef enum logic [0:0] {ST_SWEEP = 1'b0, ST_DONE = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [ROWS-1:0]     map_r, map_s;
    logic [ADDR_W-1:0]   ptr_r, ptr_s;
    logic [EPOCH_W-1:0]  epoch_r, epoch_s;
    logic [ADDR_W:0]     fresh_r, fresh_s;
    logic                miss_r, miss_s;
    logic [MISS_W-1:0]   miss_cnt_r, miss_cnt_s;
    logic                urgent_r, urgent_s;

    logic [ADDR_W-1:0]   scan_addr_s, scan_idx_s;
    logic                scan_hit_s;
    int                  scan_sum_s;
    logic                ref_req_s, ack_take_s, user_ok_s, rollover_s;
    logic                new_ack_s, new_user_s;

    // Circular search for the first stale row starting at the pointer.
    always_comb begin
        scan_addr_s = ptr_r;
        scan_hit_s  = 1'b0;
        scan_sum_s  = 0;
        scan_idx_s  = ptr_r;
        for (int i = 0; i < ROWS; i++) begin
            scan_sum_s = int'(ptr_r) + i;
            if (scan_sum_s >= ROWS) begin
                scan_sum_s = scan_sum_s - ROWS;
            end else begin
                scan_sum_s = scan_sum_s;
            end
            scan_idx_s = ADDR_W'(scan_sum_s);
            if (!scan_hit_s && !map_r[scan_idx_s]) begin
                scan_addr_s = scan_idx_s;
                scan_hit_s  = 1'b1;
            end else begin
                scan_hit_s  = scan_hit_s;
            end
        end
    end

    assign ref_req_s  = bus.en && (state_r == ST_SWEEP) && (fresh_r != ROWS_CNT);
    assign ack_take_s = ref_req_s && bus.ref_ack;
    assign user_ok_s  = bus.user_vld && (int'({1'b0, bus.user_addr}) < ROWS);
    assign rollover_s = bus.en && (epoch_r == EPOCH_LAST);
    assign new_ack_s  = ack_take_s && !map_r[scan_addr_s];
    // A row marked by both sources in one cycle is credited to the refresh side only.
    assign new_user_s = user_ok_s && !map_r[bus.user_addr] &&
                        !(ack_take_s && (bus.user_addr == scan_addr_s));

    // Next-state: epoch rollover clears everything and drops same-cycle marks.
    always_comb begin
        map_s      = map_r;
        ptr_s      = ptr_r;
        epoch_s    = epoch_r;
        fresh_s    = fresh_r;
        state_s    = state_r;
        miss_s     = 1'b0;
        miss_cnt_s = miss_cnt_r;
        if (rollover_s) begin
            map_s   = '0;
            ptr_s   = '0;
            epoch_s = '0;
            fresh_s = '0;
            state_s = ST_SWEEP;
            miss_s  = (fresh_r != ROWS_CNT);
            if (miss_s && (miss_cnt_r != {MISS_W{1'b1}})) begin
                miss_cnt_s = miss_cnt_r + MISS_W'(1);
            end else begin
                miss_cnt_s = miss_cnt_r;
            end
        end else begin
            if (ack_take_s) begin
                map_s[scan_addr_s] = 1'b1;
                if (int'({1'b0, scan_addr_s}) == ROWS - 1) begin
                    ptr_s = '0;
                end else begin
                    ptr_s = scan_addr_s + ADDR_W'(1);
                end
            end else begin
                ptr_s = ptr_r;
            end
            if (user_ok_s) begin
                map_s[bus.user_addr] = 1'b1;
            end else begin
                map_s = map_s;
            end
            fresh_s = fresh_r + (ADDR_W + 1)'(new_ack_s) + (ADDR_W + 1)'(new_user_s);
            if (bus.en) begin
                epoch_s = epoch_r + EPOCH_W'(1);
            end else begin
                epoch_s = epoch_r;
            end
            case (state_r)
                ST_SWEEP: state_s = (fresh_s == ROWS_CNT) ? ST_DONE : ST_SWEEP;
                ST_DONE:  state_s = ST_DONE;
                default:  state_s = ST_SWEEP;
            endcase
        end
        urgent_s = (state_s == ST_SWEEP) && (int'({1'b0, epoch_s}) >= URG_TH);
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_SWEEP;
            map_r      <= '0;
            ptr_r      <= '0;
            epoch_r    <= '0;
            fresh_r    <= '0;
            miss_r     <= 1'b0;
            miss_cnt_r <= '0;
            urgent_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            map_r      <= map_s;
            ptr_r      <= ptr_s;
            epoch_r    <= epoch_s;
            fresh_r    <= fresh_s;
            miss_r     <= miss_s;
            miss_cnt_r <= miss_cnt_s;
            urgent_r   <= urgent_s;
        end
    end

    assign bus.ref_req   = ref_req_s;
    assign bus.ref_addr  = scan_addr_s;
    assign bus.done      = (state_r == ST_DONE);
    assign bus.urgent    = urgent_r;
    assign bus.fresh_cnt = fresh_r;
    assign bus.miss      = miss_r;
    assign bus.miss_cnt  = miss_cnt_r;

`ifdef REFRESH_STATS_EN
    logic [ADDR_W:0] cur_user_r, cur_ref_r, stat_user_r, stat_ref_r;

    // Running per-epoch first-mark counts, published at each rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_user_r  <= '0;
            cur_ref_r   <= '0;
            stat_user_r <= '0;
            stat_ref_r  <= '0;
        end else if (rollover_s) begin
            stat_user_r <= cur_user_r;
            stat_ref_r  <= cur_ref_r;
            cur_user_r  <= '0;
            cur_ref_r   <= '0;
        end else begin
            cur_user_r  <= cur_user_r + (ADDR_W + 1)'(new_user_s);
            cur_ref_r   <= cur_ref_r + (ADDR_W + 1)'(new_ack_s);
        end
    end

    assign bus.stat_user = stat_user_r;
    assign bus.stat_ref  = stat_ref_r;
`endif
endmodule

// File: tb/tb_refresh_scoreboard_epoch.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random run vs row-set model.
module tb_refresh_scoreboard_epoch;
    localparam int ROWS   = 8;
    localparam int ADDR_W = 3;
    localparam int RET    = 64;
    localparam int URG    = 16;
    localparam int MISS_W = 2;
    localparam int MAXM   = (1 << MISS_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    refresh_scoreboard_epoch_if #(.ADDR_W(ADDR_W), .MISS_W(MISS_W)) bus ();

    refresh_scoreboard_epoch #(
        .ROWS(ROWS), .ADDR_W(ADDR_W), .RET_CYCLES(RET),
        .URGENT_MARGIN(URG), .MISS_W(MISS_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en; bit uv; int ua; bit ack;
        bit exp_req; bit chk_addr; int exp_addr; int exp_fresh; bit exp_done;
    } vec_t;
    vec_t tbl[9];

    // reference model: set of fresh rows, scan pointer, epoch position, miss history
    bit m_fresh[ROWS];
    int m_ptr, m_epoch, m_misscnt, m_cu, m_cr, m_su, m_sr;
    bit m_miss;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit e, bit uv, int ua, bit ack);
        bus.en        = e;
        bus.user_vld  = uv;
        bus.user_addr = ADDR_W'(ua);
        bus.ref_ack   = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < ROWS; r++) n += int'(m_fresh[r]);
        return n;
    endfunction

    function automatic int m_addr();
        for (int i = 0; i < ROWS; i++)
            if (!m_fresh[(m_ptr + i) % ROWS]) return (m_ptr + i) % ROWS;
        return -1;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < ROWS; r++) m_fresh[r] = 1'b0;
        m_ptr = 0; m_epoch = 0; m_misscnt = 0; m_miss = 1'b0;
        m_cu = 0; m_cr = 0; m_su = 0; m_sr = 0;
    endtask

    task automatic m_step(bit e, bit uv, int ua, bit ack);
        int cnt = m_count();
        int ra  = m_addr();
        if (e && m_epoch == RET - 1) begin
            m_miss = (cnt < ROWS);
            if (m_miss && m_misscnt < MAXM) m_misscnt++;
            for (int r = 0; r < ROWS; r++) m_fresh[r] = 1'b0;
            m_ptr = 0; m_epoch = 0;
            m_su = m_cu; m_sr = m_cr; m_cu = 0; m_cr = 0;
        end else begin
            m_miss = 1'b0;
            if (e && cnt < ROWS && ack) begin
                if (!m_fresh[ra]) m_cr++;
                m_fresh[ra] = 1'b1;
                m_ptr = (ra + 1) % ROWS;
            end
            if (uv && ua < ROWS) begin
                if (!m_fresh[ua]) m_cu++;
                m_fresh[ua] = 1'b1;
            end
            if (e) m_epoch++;
        end
    endtask

    task automatic m_check(bit e);
        int cnt = m_count();
        chk("rnd_req", 32'(bus.ref_req), 32'(e && cnt < ROWS));
        if (e && cnt < ROWS) chk("rnd_addr", 32'(bus.ref_addr), 32'(m_addr()));
        chk("rnd_fresh", 32'(bus.fresh_cnt), 32'(cnt));
        chk("rnd_done", 32'(bus.done), 32'(cnt == ROWS));
        chk("rnd_urgent", 32'(bus.urgent), 32'(cnt < ROWS && m_epoch >= RET - URG));
        chk("rnd_miss", 32'(bus.miss), 32'(m_miss));
        chk("rnd_miss_cnt", 32'(bus.miss_cnt), 32'(m_misscnt));
`ifdef REFRESH_STATS_EN
        chk("rnd_stat_user", 32'(bus.stat_user), 32'(m_su));
        chk("rnd_stat_ref", 32'(bus.stat_ref), 32'(m_sr));
`endif
    endtask

    initial begin
        int  ack_pct;
        bit  e, uv, ack;
        int  ua;

        tbl[0] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 0, 1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b1, 0, 2, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 3, 3, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 4, 4, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b1, 5, 5, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b1, 6, 6, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 7, 7, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 8, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 8, 1'b1};

        // reset state
        do_reset();
        #1;
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_urgent", 32'(bus.urgent), 32'd0);
        chk("rst_fresh", 32'(bus.fresh_cnt), 32'd0);
        chk("rst_miss", 32'(bus.miss), 32'd0);
        chk("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        chk("rst_req_en0", 32'(bus.ref_req), 32'd0);
        chk("rst_addr", 32'(bus.ref_addr), 32'd0);

        // back-to-back acks sweep rows 0..7, then rollover with all rows fresh
        drive(1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < ROWS; i++) begin
            #1;
            chk("seq_req", 32'(bus.ref_req), 32'd1);
            chk("seq_addr", 32'(bus.ref_addr), 32'(i));
            tick();
        end
        chk("seq_done", 32'(bus.done), 32'd1);
        chk("seq_fresh", 32'(bus.fresh_cnt), 32'd8);
        chk("seq_req_off", 32'(bus.ref_req), 32'd0);
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (55) tick();
        chk("seq_done_hold", 32'(bus.done), 32'd1);
        tick();
        chk("seq_done_clr", 32'(bus.done), 32'd0);
        chk("seq_no_miss", 32'(bus.miss), 32'd0);
        chk("seq_fresh_clr", 32'(bus.fresh_cnt), 32'd0);

        // vector table: user pre-marks, user-on-ref_addr skip, same-row collision
        do_reset();
        for (int v = 0; v < 9; v++) begin
            drive(tbl[v].en, tbl[v].uv, tbl[v].ua, tbl[v].ack);
            tick();
            chk("tbl_req", 32'(bus.ref_req), 32'(tbl[v].exp_req));
            if (tbl[v].chk_addr) chk("tbl_addr", 32'(bus.ref_addr), 32'(tbl[v].exp_addr));
            chk("tbl_fresh", 32'(bus.fresh_cnt), 32'(tbl[v].exp_fresh));
            chk("tbl_done", 32'(bus.done), 32'(tbl[v].exp_done));
        end
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (55) tick();
        chk("tbl_no_miss", 32'(bus.miss), 32'd0);
`ifdef REFRESH_STATS_EN
        chk("tbl_stat_user", 32'(bus.stat_user), 32'd3);
        chk("tbl_stat_ref", 32'(bus.stat_ref), 32'd5);
`endif

        // no acks: urgent window, then a miss pulse
        do_reset();
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (47) tick();
        chk("urg_47", 32'(bus.urgent), 32'd0);
        tick();
        chk("urg_48", 32'(bus.urgent), 32'd1);
        repeat (15) tick();
        chk("urg_63", 32'(bus.urgent), 32'd1);
        chk("miss_pre", 32'(bus.miss), 32'd0);
        tick();
        chk("miss_pulse", 32'(bus.miss), 32'd1);
        chk("miss_cnt1", 32'(bus.miss_cnt), 32'd1);
        chk("miss_fresh", 32'(bus.fresh_cnt), 32'd0);
        chk("miss_addr", 32'(bus.ref_addr), 32'd0);
        chk("miss_urg_clr", 32'(bus.urgent), 32'd0);
        tick();
        chk("miss_one_cycle", 32'(bus.miss), 32'd0);

        // asynchronous reset mid-sweep with four rows fresh
        drive(1'b1, 1'b0, 0, 1'b1);
        repeat (4) tick();
        chk("arst_pre_fresh", 32'(bus.fresh_cnt), 32'd4);
        drive(1'b1, 1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fresh", 32'(bus.fresh_cnt), 32'd0);
        chk("arst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_addr", 32'(bus.ref_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_rel_addr", 32'(bus.ref_addr), 32'd0);

        // ack and user mark on the rollover cycle are dropped; then saturation
        do_reset();
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (63) tick();
        drive(1'b1, 1'b1, 3, 1'b1);
        tick();
        chk("roll_fresh", 32'(bus.fresh_cnt), 32'd0);
        chk("roll_addr", 32'(bus.ref_addr), 32'd0);
        chk("roll_miss", 32'(bus.miss), 32'd1);
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (3 * RET) tick();
        chk("sat_miss_cnt", 32'(bus.miss_cnt), 32'(MAXM));

        // randomized run against the row-set model
        do_reset();
        m_reset();
        ack_pct = 20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) ack_pct = $urandom_range(0, 40);
            e   = ($urandom_range(0, 9) != 0);
            uv  = ($urandom_range(0, 99) < 8);
            ua  = $urandom_range(0, ROWS - 1);
            ack = ($urandom_range(0, 99) < ack_pct);
            drive(e, uv, ua, ack);
            #1;
            m_check(e);
            m_step(e, uv, ua, ack);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
